// File: rtl/i2c_target_regs.sv
// I2C target exposing a small byte register file with an auto-incrementing pointer.
// Optional input majority filtering is enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_regs #(
    parameter logic [6:0]  TARGET_ADDR = 7'h3C,
    parameter int unsigned NUM_REGS    = 8,
    localparam int unsigned IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scl_i,
    input  logic                    sda_i,
    output logic                    sda_oe,
    output logic [8*NUM_REGS-1:0]   regs_o,
    output logic                    wr_stb,
    output logic [IDX_W-1:0]        wr_idx,
    output logic                    busy
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, WAIT_STOP
    } state_t;

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_s;
    logic       sda_s;
    logic       scl_q;
    logic       sda_q;

    // Two-flop synchronizers; idle bus reads high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority of the newest three samples: single-cycle pulses never propagate
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_hist <= 2'b11;
            sda_hist <= 2'b11;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[1]};
            sda_hist <= {sda_hist[0], sda_sync[1]};
            scl_filt <= maj3(scl_sync[1], scl_hist[0], scl_hist[1]);
            sda_filt <= maj3(sda_sync[1], sda_hist[0], sda_hist[1]);
        end
    end

    assign scl_s = scl_filt;
    assign sda_s = sda_filt;
`else
    assign scl_s = scl_sync[1];
    assign sda_s = sda_sync[1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 1'b1;
            sda_q <= 1'b1;
        end else begin
            scl_q <= scl_s;
            sda_q <= sda_s;
        end
    end

    state_t           state;
    logic [2:0]       bit_cnt;
    logic [6:0]       rx_sh;
    logic [7:0]       tx_sh;
    logic             rw_q;
    logic [IDX_W-1:0] ptr;
    logic [7:0]       regs [NUM_REGS];

    logic             scl_rise_c;
    logic             scl_fall_c;
    logic             start_c;
    logic             stop_c;
    logic             byte_done_c;
    logic [7:0]       rx_byte_c;
    logic [IDX_W-1:0] ptr_inc_c;

    // Bus event decode; START/STOP require SCL high on both samples
    always_comb begin
        scl_rise_c  = scl_s & ~scl_q;
        scl_fall_c  = ~scl_s & scl_q;
        start_c     = scl_s & scl_q & sda_q & ~sda_s;
        stop_c      = scl_s & scl_q & ~sda_q & sda_s;
        byte_done_c = scl_rise_c && (bit_cnt == 3'd7);
        rx_byte_c   = {rx_sh, sda_s};
        ptr_inc_c   = ptr + IDX_W'(1);
    end

    // Protocol FSM; SDA drive only moves on SCL falling edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            rx_sh   <= 7'd0;
            tx_sh   <= 8'd0;
            rw_q    <= 1'b0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            wr_stb  <= 1'b0;
            wr_idx  <= '0;
            busy    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            wr_stb <= 1'b0;
            if (start_c) begin
                state   <= ADDR;
                bit_cnt <= 3'd0;
            end else if (stop_c) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (scl_rise_c) begin
                case (state)
                    ADDR: begin
                        rx_sh   <= {rx_sh[5:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done_c) begin
                            if (rx_sh == TARGET_ADDR) begin
                                state <= ADDR_ACK;
                                rw_q  <= sda_s;
                                busy  <= 1'b1;
                            end else begin
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt <= 3'd0;
                        if (rw_q) begin
                            state <= RD;
                            tx_sh <= regs[ptr];
                        end else begin
                            state <= PTR;
                        end
                    end
                    PTR: begin
                        rx_sh   <= {rx_sh[5:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done_c) begin
                            ptr   <= rx_byte_c[IDX_W-1:0];
                            state <= PTR_ACK;
                        end
                    end
                    PTR_ACK: begin
                        bit_cnt <= 3'd0;
                        state   <= WR;
                    end
                    WR: begin
                        rx_sh   <= {rx_sh[5:0], sda_s};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done_c) begin
                            regs[ptr] <= rx_byte_c;
                            wr_stb    <= 1'b1;
                            wr_idx    <= ptr;
                            ptr       <= ptr_inc_c;
                            state     <= WR_ACK;
                        end
                    end
                    WR_ACK: begin
                        bit_cnt <= 3'd0;
                        state   <= WR;
                    end
                    RD: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (byte_done_c) begin
                            state <= RD_ACK;
                        end
                    end
                    RD_ACK: begin
                        bit_cnt <= 3'd0;
                        if (!sda_s) begin
                            ptr   <= ptr_inc_c;
                            tx_sh <= regs[ptr_inc_c];
                            state <= RD;
                        end else begin
                            state <= WAIT_STOP;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall_c) begin
                case (state)
                    ADDR_ACK, PTR_ACK, WR_ACK: sda_oe <= 1'b1;
                    RD: begin
                        sda_oe <= ~tx_sh[7];
                        tx_sh  <= {tx_sh[6:0], 1'b0};
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_o[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed plus randomized bench for i2c_target_regs against an array-based register model.
module tb_i2c_target_regs;

    localparam int unsigned NREG = 8;
    localparam int unsigned IW   = $clog2(NREG);
    localparam int          T    = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 scl_i;
    logic                 sda_i;
    logic                 sda_m;
    logic                 sda_oe;
    logic [8*NREG-1:0]    regs_o;
    logic                 wr_stb;
    logic [IW-1:0]        wr_idx;
    logic                 busy;

    always #5 clk = ~clk;

    // Open-drain bus: controller and target both pull low
    assign sda_i = sda_m & ~sda_oe;

    i2c_target_regs #(.TARGET_ADDR(7'h3C), .NUM_REGS(NREG)) dut (
        .clk    (clk),
        .rst    (rst),
        .scl_i  (scl_i),
        .sda_i  (sda_i),
        .sda_oe (sda_oe),
        .regs_o (regs_o),
        .wr_stb (wr_stb),
        .wr_idx (wr_idx),
        .busy   (busy)
    );

    int          total = 0;
    int          bad   = 0;
    int          wr_log[$];
    int          oe_cnt = 0;
    logic [7:0]  mdl [NREG];
    int          mptr;
    logic [7:0]  dbuf [8];
    int          base;
    int          oe_base;
    bit          ack;
    logic [7:0]  rb;
    int          p;
    int          n;

    always @(negedge clk) begin
        if (wr_stb) wr_log.push_back(int'(wr_idx));
        if (sda_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(T);
        scl_i = 1'b1; tick(T);
        sda_m = 1'b0; tick(T);
        scl_i = 1'b0; tick(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(T);
        scl_i = 1'b1; tick(T);
        sda_m = 1'b1; tick(T);
    endtask

    task automatic send_byte(input logic [7:0] b, output bit a);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(T);
            scl_i = 1'b1; tick(T);
            scl_i = 1'b0; tick(T);
        end
        sda_m = 1'b1; tick(T);
        scl_i = 1'b1; tick(T/2);
        a = (sda_i == 1'b0);
        tick(T/2);
        scl_i = 1'b0; tick(T);
    endtask

    task automatic recv_byte(input bit nack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(T);
            scl_i = 1'b1; tick(T/2);
            b[i] = sda_i;
            tick(T/2);
            scl_i = 1'b0; tick(T);
        end
        sda_m = nack; tick(T);
        scl_i = 1'b1; tick(T);
        scl_i = 1'b0; tick(T);
    endtask

    function automatic logic [63:0] model_flat();
        logic [63:0] f = '0;
        for (int i = 0; i < NREG; i++) f[8*i +: 8] = mdl[i];
        return f;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) mdl[i] = 8'h00;
        mptr = 0;
    endtask

    // Write transaction of cnt bytes from dbuf starting at pointer pv
    task automatic do_write(input int pv, input int cnt);
        int exp_idx[$];
        bit a;
        int b0;
        b0 = wr_log.size();
        i2c_start();
        send_byte(8'h78, a);  check("wr_addr_ack", 64'(a), 64'd1);
        send_byte(8'(pv), a); check("wr_ptr_ack", 64'(a), 64'd1);
        mptr = pv % NREG;
        for (int k = 0; k < cnt; k++) begin
            send_byte(dbuf[k], a);
            check("wr_data_ack", 64'(a), 64'd1);
            mdl[mptr] = dbuf[k];
            exp_idx.push_back(mptr);
            mptr = (mptr + 1) % NREG;
        end
        check("wr_busy", 64'(busy), 64'd1);
        i2c_stop();
        check("wr_busy_after_stop", 64'(busy), 64'd0);
        check("wr_regs", 64'(regs_o), model_flat());
        check("wr_stb_count", 64'(wr_log.size() - b0), 64'(cnt));
        for (int k = 0; k < cnt && (b0 + k) < wr_log.size(); k++)
            check("wr_idx", 64'(wr_log[b0 + k]), 64'(exp_idx[k]));
    endtask

    // Set pointer, repeated START, read cnt bytes (last one NACKed)
    task automatic do_read(input int pv, input int cnt);
        bit a;
        logic [7:0] d;
        i2c_start();
        send_byte(8'h78, a);  check("rd_waddr_ack", 64'(a), 64'd1);
        send_byte(8'(pv), a); check("rd_ptr_ack", 64'(a), 64'd1);
        mptr = pv % NREG;
        i2c_start();
        send_byte(8'h79, a);  check("rd_raddr_ack", 64'(a), 64'd1);
        for (int k = 0; k < cnt; k++) begin
            recv_byte(k == cnt - 1, d);
            check("rd_data", 64'(d), 64'(mdl[mptr]));
            if (k != cnt - 1) mptr = (mptr + 1) % NREG;
        end
        check("rd_release_after_nack", 64'(sda_oe), 64'd0);
        i2c_stop();
        check("rd_busy_after_stop", 64'(busy), 64'd0);
    endtask

    initial begin
        rst   = 1'b1;
        scl_i = 1'b1;
        sda_m = 1'b1;
        model_reset();
        tick(4);
        check("rst_sda_oe", 64'(sda_oe), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_wr_stb", 64'(wr_stb), 64'd0);
        check("rst_regs", 64'(regs_o), 64'd0);
        rst = 1'b0;
        tick(4);

        // Basic write with auto-increment
        dbuf[0] = 8'hA5; dbuf[1] = 8'h5A;
        do_write(2, 2);
        check("reg2_a5", 64'(regs_o[23:16]), 64'hA5);
        check("reg3_5a", 64'(regs_o[31:24]), 64'h5A);

        // Pointer wrap from the last register
        dbuf[0] = 8'h11; dbuf[1] = 8'h22;
        do_write(7, 2);
        check("reg7_11", 64'(regs_o[63:56]), 64'h11);
        check("reg0_22", 64'(regs_o[7:0]), 64'h22);

        // Pointer write, repeated START, two-byte read
        do_read(2, 2);

        // Foreign address is ignored entirely
        oe_base = oe_cnt;
        base    = wr_log.size();
        i2c_start();
        send_byte(8'h7A, ack); check("nomatch_addr_ack", 64'(ack), 64'd0);
        send_byte(8'hFF, ack); check("nomatch_data_ack", 64'(ack), 64'd0);
        check("nomatch_busy", 64'(busy), 64'd0);
        i2c_stop();
        check("nomatch_oe_never", 64'(oe_cnt - oe_base), 64'd0);
        check("nomatch_no_stb", 64'(wr_log.size() - base), 64'd0);
        check("nomatch_regs", 64'(regs_o), model_flat());

        // Randomized writes and reads against the model
        for (int it = 0; it < 6; it++) begin
            p = int'($urandom_range(0, 255));
            n = int'($urandom_range(1, 4));
            for (int k = 0; k < n; k++) dbuf[k] = 8'($urandom);
            do_write(p, n);
            do_read(int'($urandom_range(0, 255)), int'($urandom_range(1, 4)));
        end

        // Reset in the middle of reading a 0x00 byte (target drives low on every bit)
        dbuf[0] = 8'h00;
        do_write(5, 1);
        i2c_start();
        send_byte(8'h78, ack); check("pre_rst_waddr_ack", 64'(ack), 64'd1);
        send_byte(8'h05, ack); check("pre_rst_ptr_ack", 64'(ack), 64'd1);
        i2c_start();
        send_byte(8'h79, ack); check("pre_rst_raddr_ack", 64'(ack), 64'd1);
        for (int i = 0; i < 3; i++) begin
            sda_m = 1'b1; tick(T);
            scl_i = 1'b1; tick(T);
            scl_i = 1'b0; tick(T);
        end
        sda_m = 1'b1; tick(T);
        scl_i = 1'b1; tick(T/2);
        check("rd_bit4_driving", 64'(sda_oe), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_async_release", 64'(sda_oe), 64'd0);
        check("rst_async_regs", 64'(regs_o), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        model_reset();
        tick(2);
        scl_i = 1'b1;
        sda_m = 1'b1;
        tick(4);
        rst = 1'b0;
        tick(4);
        dbuf[0] = 8'hC3;
        do_write(1, 1);
        check("post_rst_reg1", 64'(regs_o[15:8]), 64'hC3);

        // One-cycle SDA low pulse while SCL high, SCL falling right after
        @(posedge clk); #1;
        sda_m = 1'b0;
        @(posedge clk); #1;
        sda_m = 1'b1;
        scl_i = 1'b0;
        tick(T);
        send_byte(8'h78, ack);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        check("glitch_ack", 64'(ack), 64'd0);
        check("glitch_busy", 64'(busy), 64'd0);
`else
        check("glitch_ack", 64'(ack), 64'd1);
        check("glitch_busy", 64'(busy), 64'd1);
`endif
        i2c_stop();
        check("glitch_busy_after_stop", 64'(busy), 64'd0);
        check("glitch_regs", 64'(regs_o), model_flat());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
